// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product beat stream in, group result out (two valid/ready handshakes)
interface product_accumulator_if #(
    parameter int PW    = 64,
    parameter int AW    = 64,
    parameter int CNT_W = 16
);
    logic [PW-1:0]    in_prod;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [AW-1:0]    out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_prod, in_valid, in_last, out_ready,
        input  in_ready, out_acc, out_count, out_ovf, out_valid
    );

    modport slave (
        input  in_prod, in_valid, in_last, out_ready,
        output in_ready, out_acc, out_count, out_ovf, out_valid
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums signed product groups closed by a last beat; SATURATE_EN clamps on overflow instead of wrapping
module product_accumulator #(
    parameter int PW    = 64,
    parameter int AW    = 64,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state, state_next;
    logic [PW-1:0]           prod;
    logic signed [AW-1:0]    prod_ext, acc, raw_sum, sum, acc_out;
    logic [CNT_W-1:0]        cnt, cnt_inc, count_out;
    logic                    ovf, ovf_next, ovf_out, add_ovf;
    logic                    in_ready, out_valid, accept;

    assign prod     = bus.in_prod;
    assign prod_ext = AW'($signed(prod));
    assign raw_sum  = acc + prod_ext;
    assign add_ovf  = (acc[AW-1] == prod_ext[AW-1]) && (raw_sum[AW-1] != acc[AW-1]);
    assign ovf_next = ovf | add_ovf;
    assign cnt_inc  = &cnt ? cnt : cnt + 1'b1;
    assign accept   = bus.in_valid && in_ready;
`ifdef SATURATE_EN
    // Overflow direction follows the common operand sign: both negative clamps low, both positive clamps high
    assign sum = add_ovf ? (acc[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}}) : raw_sum;
`else
    assign sum = raw_sum;
`endif

    // Handshake outputs follow the state; close a group on an accepted last beat, release on result handshake
    always_comb begin
        in_ready   = state == ACCUM;
        out_valid  = state == HOLD;
        state_next = (state == ACCUM && accept && bus.in_last) ? HOLD :
                     (state == HOLD && bus.out_ready)          ? ACCUM : state;
    end

    // State register, running group sum and the held result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            acc_out   <= '0;
            count_out <= '0;
            ovf_out   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && bus.in_last) begin
                acc_out   <= sum;
                count_out <= cnt_inc;
                ovf_out   <= ovf_next;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else if (accept) begin
                acc <= sum;
                cnt <= cnt_inc;
                ovf <= ovf_next;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_acc   = acc_out;
    assign bus.out_count = count_out;
    assign bus.out_ovf   = ovf_out;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench for product_accumulator (honours SATURATE_EN)
module tb_product_accumulator;
    typedef struct packed {
        logic [63:0] acc;
        logic [15:0] cnt;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    res_t exp_q[$];
    res_t held;
    int   tests = 0;
    int   fails = 0;
    logic signed [63:0] m_acc;
    int   m_cnt;
    logic m_ovf;

    product_accumulator_if bus ();
    product_accumulator dut (.clk(clk), .rst(rst), .bus(bus));

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Reference: 65-bit add, overflow when the two top bits disagree
    task automatic model_add(input logic [63:0] p, input logic last);
        logic [64:0] s;
        logic        ov;
        s  = {m_acc[63], m_acc} + {p[63], p};
        ov = s[64] ^ s[63];
`ifdef SATURATE_EN
        m_acc = ov ? (s[64] ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF) : s[63:0];
`else
        m_acc = s[63:0];
`endif
        m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
        m_ovf = m_ovf | ov;
        if (last) begin
            exp_q.push_back('{m_acc, 16'(m_cnt), m_ovf});
            model_clear();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for in_ready, let the accepting edge pass
    task automatic beat(input logic [63:0] p, input logic last);
        int n = 0;
        bus.in_prod  = p;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            idle(1);
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end else begin
            idle(1);
            bus.in_valid = 1'b0;
            model_add(p, last);
        end
    endtask

    // Monitor: compare each result handshake against the scoreboard head
    initial begin : mon
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("out_acc", bus.out_acc, e.acc);
                    check("out_count", 64'(bus.out_count), 64'(e.cnt));
                    check("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b1;
        model_clear();
        idle(2);
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_out_acc", bus.out_acc, 0);
        check("rst_out_count", 64'(bus.out_count), 0);
        check("rst_out_ovf", 64'(bus.out_ovf), 0);
        rst = 1'b0;

        beat(64'h1BB6BAA0, 1'b0);
        beat(64'hFFFFFFFFF7747564, 1'b1);
        check("latency_out_valid", 64'(bus.out_valid), 1);
        check("hold_in_ready", 64'(bus.in_ready), 0);

        beat(64'h193DE4CED7437964, 1'b1);

        beat(64'h7FFFFFFFFFFFFFFF, 1'b0);
        beat(64'h1, 1'b1);
        idle(2);

        bus.out_ready = 1'b0;
        beat(64'h5, 1'b0);
        beat(64'h7, 1'b1);
        held = exp_q[$];
        bus.in_prod  = 64'h99;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 0);
            check("bp_out_valid", 64'(bus.out_valid), 1);
            check("bp_out_acc", bus.out_acc, held.acc);
            check("bp_out_count", 64'(bus.out_count), 64'(held.cnt));
        end
        idle(1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        beat(64'h9, 1'b1);

        beat(64'h10, 1'b0);
        beat(64'h20, 1'b0);
        rst = 1'b1;
        idle(1);
        model_clear();
        check("midrst_out_valid", 64'(bus.out_valid), 0);
        check("midrst_in_ready", 64'(bus.in_ready), 1);
        rst = 1'b0;
        beat(64'h5, 1'b1);

        beat(64'h3, 1'b0);
        idle(2);
        beat(64'hFFFFFFFFFFFFFFFF, 1'b0);
        idle(2);
        beat(64'h0, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        idle(2);
        check("scoreboard_drain", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
